// File: rtl/keccak_absorb_loader.sv
// rtl/keccak_absorb_loader.sv - packs an AXI-Stream byte message into rate-sized Keccak-f[1600] blocks.
// Optional hardware SHA3 domain padding is enabled with `define KECCAK_HW_PAD_EN.
module keccak_absorb_loader #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_W     = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_W-1:0]     s_tkeep,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [1:0]            s_tuser,
  output logic [1599:0]         block_data,
  output logic                  block_valid,
  input  logic                  block_ready,
  output logic                  block_last,
  output logic [1:0]            block_mode
);

`ifdef KECCAK_HW_PAD_EN
  typedef enum logic [1:0] {FILL, EMIT, PAD} state_t;
`else
  typedef enum logic [1:0] {FILL, EMIT} state_t;
`endif

  state_t        state_q, state_d;
  logic [1599:0] blk_q, blk_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic          last_q, last_d;
  logic          open_q, open_d;
`ifdef KECCAK_HW_PAD_EN
  logic          pend_q, pend_d;
`endif

  logic [1:0]        mode_cur;
  logic [7:0]        rate;
  logic [KEEP_W-1:0] keep_eff;
  logic [7:0]        pop;
  logic [7:0]        n_bytes;

  function automatic logic [7:0] rate_of(input logic [1:0] m);
    case (m)
      2'd0:    rate_of = 8'd144;
      2'd1:    rate_of = 8'd136;
      2'd2:    rate_of = 8'd104;
      default: rate_of = 8'd72;
    endcase
  endfunction

  assign block_data = blk_q;
  assign block_last = last_q;
  assign block_mode = mode_q;

  // The variant is taken live from s_tuser only on the opening beat of a message.
  always_comb begin
    mode_cur = open_q ? mode_q : s_tuser;
    rate     = rate_of(mode_cur);
    keep_eff = s_tlast ? s_tkeep : {KEEP_W{1'b1}};
    pop      = 8'd0;
    for (int i = 0; i < KEEP_W; i++) begin
      if (keep_eff[i]) pop = pop + 8'd1;
    end
    n_bytes = cnt_q + pop;
  end

  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    last_d      = last_q;
    open_d      = open_q;
`ifdef KECCAK_HW_PAD_EN
    pend_d      = pend_q;
`endif
    s_tready    = 1'b0;
    block_valid = 1'b0;

    case (state_q)
      FILL: begin
        s_tready = !ARESET;
        if (s_tvalid && !ARESET) begin
          mode_d = mode_cur;
          for (int i = 0; i < KEEP_W; i++) begin
            if (keep_eff[i]) blk_d[8*(int'(cnt_q)+i) +: 8] = s_tdata[8*i +: 8];
          end
          if (!s_tlast) begin
            open_d = 1'b1;
            if (n_bytes == rate) begin
              state_d = EMIT;
              cnt_d   = 8'd0;
              last_d  = 1'b0;
            end else begin
              cnt_d = n_bytes;
            end
          end else begin
            open_d  = 1'b0;
            cnt_d   = 8'd0;
            state_d = EMIT;
`ifdef KECCAK_HW_PAD_EN
            if (n_bytes < rate) begin
              blk_d[8*int'(n_bytes) +: 8]    = blk_d[8*int'(n_bytes) +: 8] ^ 8'h06;
              blk_d[8*(int'(rate)-1) +: 8]   = blk_d[8*(int'(rate)-1) +: 8] ^ 8'h80;
              last_d = 1'b1;
            end else begin
              // Message filled the rate exactly; padding goes into an extra block.
              last_d = 1'b0;
              pend_d = 1'b1;
            end
`else
            last_d = 1'b1;
`endif
          end
        end
      end

      EMIT: begin
        block_valid = !ARESET;
        if (block_ready) begin
          blk_d  = '0;
          last_d = 1'b0;
`ifdef KECCAK_HW_PAD_EN
          state_d = pend_q ? PAD : FILL;
          pend_d  = 1'b0;
`else
          state_d = FILL;
`endif
        end
      end

`ifdef KECCAK_HW_PAD_EN
      PAD: begin
        blk_d = '0;
        blk_d[7:0] = 8'h06;
        blk_d[8*(int'(rate_of(mode_q))-1) +: 8] = 8'h80;
        last_d  = 1'b1;
        state_d = EMIT;
      end
`endif

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= FILL;
      blk_q   <= '0;
      cnt_q   <= 8'd0;
      mode_q  <= 2'd0;
      last_q  <= 1'b0;
      open_q  <= 1'b0;
`ifdef KECCAK_HW_PAD_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      open_q  <= open_d;
`ifdef KECCAK_HW_PAD_EN
      pend_q  <= pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_keccak_absorb_loader.sv
// tb/tb_keccak_absorb_loader.sv - directed vector bench for keccak_absorb_loader.
// Expectations follow the build: padded blocks when KECCAK_HW_PAD_EN is defined.
module tb_keccak_absorb_loader;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [63:0]   s_tdata;
  logic [7:0]    s_tkeep;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [1:0]    s_tuser;
  logic [1599:0] block_data;
  logic          block_valid;
  logic          block_ready;
  logic          block_last;
  logic [1:0]    block_mode;

  int total  = 0;
  int passed = 0;

  keccak_absorb_loader #(.DATA_WIDTH(64)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .block_data(block_data), .block_valid(block_valid), .block_ready(block_ready),
    .block_last(block_last), .block_mode(block_mode)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [1:0]  user;
    logic [63:0] data;
    logic [7:0]  keep;
    int          n;
    int          rlast;
  } vec_t;

  vec_t vecs [4];

`ifdef KECCAK_HW_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_blk(input string name, input logic [1599:0] act, input logic [1599:0] exp);
    int k;
    total++;
    if (act === exp) passed++;
    else begin
      k = 0;
      while (k < 199 && act[8*k +: 8] === exp[8*k +: 8]) k++;
      $display("FAIL %s: byte %0d got %02h expected %02h", name, k, act[8*k +: 8], exp[8*k +: 8]);
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [1:0] u);
    int t;
    @(negedge ACLK);
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    t = 0;
    while (!s_tready && t < 200) begin
      @(negedge ACLK);
      t++;
    end
    if (!s_tready) begin
      total++;
      $display("FAIL beat_accept: s_tready stuck at 0, required 1");
    end else begin
      @(posedge ACLK);
    end
    #1 s_tvalid = 1'b0;
  endtask

  task automatic wait_block(input string name);
    int t;
    t = 0;
    @(negedge ACLK);
    while (!block_valid && t < 300) begin
      @(negedge ACLK);
      t++;
    end
    if (!block_valid) begin
      total++;
      $display("FAIL %s_timeout: block_valid got 0 required 1", name);
    end
  endtask

  task automatic take_block();
    block_ready = 1'b1;
    @(posedge ACLK);
    #1 block_ready = 1'b0;
  endtask

  function automatic logic [1599:0] pad_only(input int rlast);
    logic [1599:0] e;
    e = '0;
    e[7:0] = 8'h06;
    e[8*rlast +: 8] = 8'h80;
    return e;
  endfunction

  logic [1599:0] exp_blk, snap;
  logic [63:0]   d;

  initial begin
    vecs[0] = '{user: 2'd0, data: 64'h636261,           keep: 8'h07, n: 3, rlast: 143};
    vecs[1] = '{user: 2'd1, data: 64'h0,                keep: 8'h00, n: 0, rlast: 135};
    vecs[2] = '{user: 2'd2, data: 64'h0807060504030201, keep: 8'hFF, n: 8, rlast: 103};
    vecs[3] = '{user: 2'd3, data: 64'h00000000000000AA, keep: 8'h01, n: 1, rlast: 71};

    ARESET = 1'b1; s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tuser = '0; block_ready = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("reset_tready", 64'(s_tready), 64'd0);
    chk("reset_valid", 64'(block_valid), 64'd0);
    chk("reset_last", 64'(block_last), 64'd0);
    chk("reset_mode", 64'(block_mode), 64'd0);
    chk_blk("reset_data", block_data, '0);
    ARESET = 1'b0;

    // Single-beat messages: abc, empty, full beat, one byte.
    for (int v = 0; v < 4; v++) begin
      send_beat(vecs[v].data, vecs[v].keep, 1'b1, vecs[v].user);
      wait_block("vec");
      exp_blk = '0;
      for (int i = 0; i < vecs[v].n; i++) exp_blk[8*i +: 8] = vecs[v].data[8*i +: 8];
      if (PAD_EN) begin
        exp_blk[8*vecs[v].n +: 8]     = exp_blk[8*vecs[v].n +: 8] ^ 8'h06;
        exp_blk[8*vecs[v].rlast +: 8] = exp_blk[8*vecs[v].rlast +: 8] ^ 8'h80;
      end
      chk_blk($sformatf("vec%0d_data", v), block_data, exp_blk);
      chk($sformatf("vec%0d_last", v), 64'(block_last), 64'd1);
      chk($sformatf("vec%0d_mode", v), 64'(block_mode), 64'(vecs[v].user));
      take_block();
      @(negedge ACLK);
      chk($sformatf("vec%0d_valid_drop", v), 64'(block_valid), 64'd0);
    end

    // Reset in the middle of a block, then a fresh message.
    for (int b = 0; b < 5; b++) send_beat({8{8'hEE}}, 8'hFF, 1'b0, 2'd1);
    @(negedge ACLK);
    ARESET = 1'b1;
    #1 chk("midrst_tready", 64'(s_tready), 64'd0);
    @(posedge ACLK);
    #1 ARESET = 1'b0;
    chk("midrst_valid", 64'(block_valid), 64'd0);
    send_beat(64'h636261, 8'h07, 1'b1, 2'd1);
    wait_block("midrst");
    exp_blk = '0;
    exp_blk[23:0] = 24'h636261;
    if (PAD_EN) begin
      exp_blk[31:24] = 8'h06;
      exp_blk[8*135 +: 8] = 8'h80;
    end
    chk_blk("midrst_data", block_data, exp_blk);
    chk("midrst_mode", 64'(block_mode), 64'd1);
    take_block();

    // Exact-rate message for SHA3-512.
    for (int b = 0; b < 9; b++) send_beat({8{8'hFF}}, 8'hFF, b == 8, 2'd3);
    wait_block("exact1");
    exp_blk = '0;
    for (int i = 0; i < 72; i++) exp_blk[8*i +: 8] = 8'hFF;
    chk_blk("exact1_data", block_data, exp_blk);
    chk("exact1_last", 64'(block_last), PAD_EN ? 64'd0 : 64'd1);
    take_block();
    if (PAD_EN) begin
      wait_block("exact2");
      chk_blk("exact2_data", block_data, pad_only(71));
      chk("exact2_last", 64'(block_last), 64'd1);
      chk("exact2_mode", 64'(block_mode), 64'd3);
      take_block();
    end
    @(negedge ACLK);
    chk("exact_no_extra", 64'(block_valid), 64'd0);

    // 103-byte SHA3-384 message held under back-pressure.
    for (int b = 0; b < 13; b++) begin
      for (int i = 0; i < 8; i++) d[8*i +: 8] = 8'(8*b + i + 1);
      send_beat(d, b == 12 ? 8'h7F : 8'hFF, b == 12, 2'd2);
    end
    wait_block("bp");
    snap = block_data;
    for (int c = 0; c < 10; c++) begin
      @(negedge ACLK);
      chk("bp_tready", 64'(s_tready), 64'd0);
      chk_blk("bp_stable", block_data, snap);
    end
    exp_blk = '0;
    for (int i = 0; i < 103; i++) exp_blk[8*i +: 8] = 8'(i + 1);
    if (PAD_EN) exp_blk[8*103 +: 8] = 8'h86;
    chk_blk("bp_data", block_data, exp_blk);
    chk("bp_last", 64'(block_last), 64'd1);
    chk("bp_mode", 64'(block_mode), 64'd2);
    take_block();

    // s_tuser switched to 3 after the first beat of an 80-byte message.
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 8; i++) d[8*i +: 8] = 8'((8*b + i) ^ 8'h5A);
      send_beat(d, 8'hFF, b == 9, b == 0 ? 2'd0 : 2'd3);
      if (b == 8) begin
        @(negedge ACLK);
        chk("mode_no_early_block", 64'(block_valid), 64'd0);
      end
    end
    wait_block("mode");
    exp_blk = '0;
    for (int i = 0; i < 80; i++) exp_blk[8*i +: 8] = 8'(i ^ 8'h5A);
    if (PAD_EN) begin
      exp_blk[8*80 +: 8]  = 8'h06;
      exp_blk[8*143 +: 8] = 8'h80;
    end
    chk_blk("mode_data", block_data, exp_blk);
    chk("mode_mode", 64'(block_mode), 64'd0);
    chk("mode_last", 64'(block_last), 64'd1);
    take_block();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/keccak_absorb_loader.md
Name: keccak_absorb_loader

Overview:
- AXI-Stream slave that packs a byte message into rate-sized Keccak-f[1600] blocks for the SHA3 permutation core.
- Supports all four SHA3 variants, selected per message by TUSER.
- Applies SHA3 domain padding in hardware.
- Presents each 1600-bit block with a valid/ready handshake toward the permutation core, and back-pressures the stream while a block is pending.

Parameters:
- DATA_WIDTH, 64, stream beat width in bits; legal values 8/16/32/64.
- KEEP_W, DATA_WIDTH/8, byte-enable width; derived, not overridden.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  synchronous reset, active-high
- s_tdata  in  DATA_WIDTH  message bytes, byte 0 in bits [7:0]
- s_tkeep  in  KEEP_W  byte enables; all ones except on last beat
- s_tvalid  in  1  beat valid
- s_tready  out  1  beat accepted when s_tvalid & s_tready
- s_tlast  in  1  final beat of message
- s_tuser  in  2  variant: 0=224 (rate 144 B), 1=256 (136 B), 2=384 (104 B), 3=512 (72 B)
- block_data  out  1600  block; message byte k at [8k+7:8k], bytes >= rate zero
- block_valid  out  1  block available
- block_ready  in  1  core accepts block
- block_last  out  1  block is final (padded) block of message
- block_mode  out  2  variant latched for this message

Behaviour:
- Reset (ARESET=1 at posedge):
  - buffer, byte counter and block_mode are cleared; state goes to FILL.
  - block_valid=0, block_last=0, block_data=0.
  - s_tready=0 while ARESET is high.
  - Reset mid-message or mid-EMIT discards all partial data.
- FILL state:
  - s_tready=1.
  - Accepted beat writes its enabled bytes at offset cnt; cnt advances by popcount(s_tkeep).
- Mode latch:
  - s_tuser is sampled on the first beat of a message (cnt==0 and no message open).
  - Changes to s_tuser mid-message are ignored.
- Block boundary: non-last beat with cnt+KEEP_W == rate → EMIT, block_last=0, cnt reset for next block.
- Last beat, n = cnt+popcount(s_tkeep):
  - If n < rate: byte n ^= 0x06, byte rate-1 ^= 0x80 (n == rate-1 gives 0x86); then EMIT with block_last=1.
  - If n == rate: EMIT with block_last=0 and a pad-pending flag set. After that handshake, go to PAD.
- PAD state (1 cycle):
  - Buffer = zeros with byte 0 = 0x06 and byte rate-1 = 0x80.
  - Then EMIT with block_last=1.
- Zero-length message: last beat with s_tkeep=0 and cnt==0 yields a single pad-only block.
- EMIT state:
  - s_tready=0; block_valid=1.
  - block_data, block_last and block_mode are held stable until block_ready.
  - On handshake: buffer cleared, block_valid drops the next cycle. Next state is PAD if pad-pending, else FILL.
- Latency: block_valid rises the cycle after the beat completing the block.
- Throughput:
  - Minimum 1 idle stream cycle per block (the EMIT cycle).
  - Back-to-back blocks are allowed when block_ready is held high.
- Rate divisibility: all rates are multiples of 8 bytes, so a beat never straddles blocks.
- Illegal input: a non-last beat with s_tkeep not all ones is treated as all ones.

Optional Feature:
- Macro: KECCAK_HW_PAD_EN.
- Defined: hardware padding as above; PAD state and pad-pending flag present.
- Undefined:
  - No bytes are modified; the caller supplies a pre-padded stream.
  - A last beat with n < rate emits a zero-filled block with block_last=1.
  - n == rate emits with block_last=1 and no extra block; the PAD state is removed.

Test Plan:
- Reset mid-block:
  - Stimulus: 5 beats with s_tuser=1, then ARESET for 1 cycle, then a new message.
  - Required: block_valid=0, first new block contains only new bytes, cnt restarted.
- Empty message:
  - Stimulus: DATA_WIDTH=64, s_tuser=1, single beat tlast=1, tkeep=0x00.
  - Required: one block, byte0=0x06, byte135=0x80, rest 0, block_last=1, block_mode=1.
- Message "abc":
  - Stimulus: tdata=0x636261, tkeep=0x07, tlast=1, s_tuser=0.
  - Required: bytes 0..2 = 61 62 63, byte3=0x06, byte143=0x80, block_last=1.
- Exact-rate message:
  - Stimulus: s_tuser=3, 9 beats of 0xFF, tkeep all ones, tlast on beat 9.
  - Required: block 1 = 72 bytes of 0xFF with block_last=0; then a pad-only block, byte0=0x06, byte71=0x80, block_last=1.
- Back-pressure and rate-1 case:
  - Stimulus: block_ready held 0 for 10 cycles; s_tuser=2, 103-byte message.
  - Required: s_tready=0 and block_data stable throughout; byte103=0x86.
- Mode change mid-message:
  - Stimulus: s_tuser switched 0→3 after beat 1.
  - Required: block_mode=0 and rate 144 is kept for the whole message.
